// File: rtl/dsp_add_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_add_arb_pkg
// Description : Shared definitions for the round-robin SIMD adder scheduler.
//               Holds lane geometry, the scheduler state encoding and the
//               per-lane add function.
// Config      : DSP_ADD_ARB_SAT_EN - defined: lanes saturate to the signed
//               range [-128, 127]; undefined: lanes wrap modulo 256.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_add_arb_pkg;

    localparam int WIDTH = 8;
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } arb_state_t;

    // One independent signed lane add; no carry leaves the lane.
    function automatic logic [WIDTH-1:0] lane_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
`ifdef DSP_ADD_ARB_SAT_EN
        logic [WIDTH:0] s;
        // Sign-extend by one bit; overflow shows up as the top two bits differing.
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) begin
            return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return s[WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dsp_add_pipe
// Description : LAT-stage operand/tag/valid shift pipeline followed by the
//               lane adders and the result register. An operation entering
//               at edge k is presented on rsp_valid/rsp_y after edge k+LAT.
// Ports       : clock, reset (sync, active-low)
//               in_valid/in_tag/in_a/in_b : operation entering stage 1
//               rsp_valid : one-hot result tag, rsp_y : lane results
//               busy : an operation occupies one of the LAT stages
// Config      : DSP_ADD_ARB_SAT_EN (via dsp_add_arb_pkg::lane_add)
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_add_pipe
    import dsp_add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [NREQ-1:0]          in_tag,
    input  logic [LANES*WIDTH-1:0]   in_a,
    input  logic [LANES*WIDTH-1:0]   in_b,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [LANES*WIDTH-1:0]   rsp_y,
    output logic                     busy
);

    localparam int c_WORD = LANES * WIDTH;

    logic              r_valid [LAT];
    logic [NREQ-1:0]   r_tag   [LAT];
    logic [c_WORD-1:0] r_a     [LAT];
    logic [c_WORD-1:0] r_b     [LAT];
    logic [NREQ-1:0]   r_rsp_valid;
    logic [c_WORD-1:0] r_rsp_y;
    logic [c_WORD-1:0] w_sum;
    logic              w_busy;

    // Lane adders operate on the last operand stage; the result register
    // behind them is the extra cycle that makes total latency exactly LAT.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_sum[k*WIDTH +: WIDTH] = lane_add(r_a[LAT-1][k*WIDTH +: WIDTH],
                                                  r_b[LAT-1][k*WIDTH +: WIDTH]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < LAT; s++) begin
                r_valid[s] <= 1'b0;
                r_tag[s]   <= '0;
                r_a[s]     <= '0;
                r_b[s]     <= '0;
            end
            r_rsp_valid <= '0;
            r_rsp_y     <= '0;
        end else begin
            r_valid[0] <= in_valid;
            r_tag[0]   <= in_tag;
            r_a[0]     <= in_a;
            r_b[0]     <= in_b;
            for (int s = 1; s < LAT; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_tag[s]   <= r_tag[s-1];
                r_a[s]     <= r_a[s-1];
                r_b[s]     <= r_b[s-1];
            end
            r_rsp_valid <= r_tag[LAT-1] & {NREQ{r_valid[LAT-1]}};
            // Result holds between operations.
            if (r_valid[LAT-1]) begin
                r_rsp_y <= w_sum;
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            w_busy = w_busy | r_valid[s];
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: rtl/dsp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dsp_add_arbiter
// Description : Round-robin scheduler sharing one pipelined 4-lane signed
//               8-bit SIMD adder among NREQ requesters, with a drain/halt
//               control for quiescing the datapath.
// Ports       : clock, reset (sync, active-low)
//               req_valid/req_ready/req_a/req_b : per-requester handshake
//               rsp_valid (one-hot) / rsp_y : result, LAT cycles after grant
//               drain : stop granting; halted : drained and empty
//               busy  : an operation is in flight
// Config      : DSP_ADD_ARB_SAT_EN - saturating lane arithmetic when defined
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_add_arbiter
    import dsp_add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*LANES*WIDTH-1:0]   req_a,
    input  logic [NREQ*LANES*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [LANES*WIDTH-1:0]        rsp_y,
    input  logic                          drain,
    output logic                          halted,
    output logic                          busy
);

    localparam int c_WORD  = LANES * WIDTH;
    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_grant_idx;
    logic               w_found;
    logic               w_can_grant;
    logic               w_fire;
    logic               w_busy;
    logic [NREQ-1:0]    w_grant;
    logic [c_WORD-1:0]  w_sel_a;
    logic [c_WORD-1:0]  w_sel_b;

    // Grants are blocked during reset and whenever drain is requested, so a
    // drain rising in RUN never races with a new transfer.
    assign w_can_grant = reset && (r_state == RUN) && !drain;

    // First valid requester at or after r_ptr, wrapping at NREQ.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_grant     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[c_PTR_W'((int'(r_ptr) + i) % NREQ)]) begin
                w_found     = 1'b1;
                w_grant_idx = c_PTR_W'((int'(r_ptr) + i) % NREQ);
            end
        end
        if (w_can_grant && w_found) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    // A grant only goes to a valid requester, so any grant is a transfer.
    assign w_fire = |w_grant;

    // AND-OR operand mux keyed by the one-hot grant.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = req_a[i*c_WORD +: c_WORD];
                w_sel_b = req_b[i*c_WORD +: c_WORD];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= RUN;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_fire) begin
                r_ptr <= c_PTR_W'((int'(w_grant_idx) + 1) % NREQ);
            end
        end
    end

    // "Empty" means no operation in any operand stage; the result register
    // presenting the last response does not hold the machine in DRAIN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                if (drain) begin
                    w_next_state = w_busy ? DRAIN : HALT;
                end
            end
            DRAIN: begin
                if (!drain) begin
                    w_next_state = RUN;
                end else if (!w_busy) begin
                    w_next_state = HALT;
                end
            end
            HALT: begin
                if (!drain) begin
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    dsp_add_pipe #(
        .NREQ (NREQ),
        .LAT  (LAT)
    ) u_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (w_fire),
        .in_tag    (w_grant),
        .in_a      (w_sel_a),
        .in_b      (w_sel_b),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .busy      (w_busy)
    );

    assign req_ready = w_grant;
    assign halted    = (r_state == HALT);
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_dsp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_add_arbiter
// Description : Self-checking bench for dsp_add_arbiter. A transaction-level
//               reference (queue of expected responses, round-robin pointer,
//               run/drain/halt mode) predicts every cycle's outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_add_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid, req_ready, rsp_valid;
    logic [NREQ*32-1:0]   req_a, req_b;
    logic [31:0]          rsp_y;
    logic                 drain, halted, busy;

    always #5 clock = ~clock;

    dsp_add_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .drain     (drain),
        .halted    (halted),
        .busy      (busy)
    );

    typedef struct {
        int          due;
        int          who;
        logic [31:0] y;
    } rsp_t;

    int          total = 0;
    int          bad   = 0;
    int          n;
    int          mode;
    int          ptr;
    rsp_t        q[$];
    logic [31:0] last_y;
    logic [31:0] op_a [NREQ];
    logic [31:0] op_b [NREQ];
    bit          pend [NREQ];
    logic [NREQ-1:0] gen_mask;
    int          gen_pct;
    int          dut_grants[$];
    int          dut_rsps[$];
    logic [31:0] seen_y [NREQ];
    int          gedge  [NREQ];
    int          seen_lat [NREQ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    // Lane-wise signed add from plain integer arithmetic.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        int sa, sb, s;
        y = '0;
        for (int k = 0; k < 4; k++) begin
            sa = int'($signed(a[8*k +: 8]));
            sb = int'($signed(b[8*k +: 8]));
            s  = sa + sb;
`ifdef DSP_ADD_ARB_SAT_EN
            if (s > 127)  s = 127;
            if (s < -128) s = -128;
`endif
            y[8*k +: 8] = 8'(s);
        end
        return y;
    endfunction

    // One clock: drive inputs, check the combinational grant, take the edge,
    // then check registered outputs on the falling edge.
    task automatic cycle(input logic rst_n, input logic drn);
        int g;
        bit inflight;
        logic [NREQ-1:0] exp_g, exp_rv;
        logic [31:0] exp_y;
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && gen_mask[i] && ($urandom_range(99) < gen_pct)) begin
                pend[i] = 1'b1;
                op_a[i] = $urandom;
                op_b[i] = $urandom;
            end
            req_valid[i]        = pend[i];
            req_a[32*i +: 32]   = op_a[i];
            req_b[32*i +: 32]   = op_b[i];
        end
        reset = rst_n;
        drain = drn;
        #1;
        g = -1;
        if (rst_n && mode == M_RUN && !drn) begin
            for (int o = 0; o < NREQ; o++) begin
                if (g < 0 && pend[(ptr + o) % NREQ]) g = (ptr + o) % NREQ;
            end
        end
        exp_g = '0;
        if (g >= 0) exp_g[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_g));
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                dut_grants.push_back(i);
                gedge[i] = n + 1;
            end
        end
        inflight = (q.size() > 0);
        @(posedge clock);
        n++;
        if (!rst_n) begin
            q.delete();
            ptr    = 0;
            mode   = M_RUN;
            last_y = '0;
        end else begin
            case (mode)
                M_RUN:   if (drn) mode = inflight ? M_DRAIN : M_HALT;
                M_DRAIN: if (!drn) mode = M_RUN; else if (!inflight) mode = M_HALT;
                default: if (!drn) mode = M_RUN;
            endcase
            if (g >= 0) begin
                q.push_back('{n + LAT, g, ref_add(op_a[g], op_b[g])});
                pend[g] = 1'b0;
                ptr     = (g + 1) % NREQ;
            end
        end
        @(negedge clock);
        exp_rv = '0;
        exp_y  = last_y;
        if (q.size() > 0 && q[0].due == n) begin
            exp_rv[q[0].who] = 1'b1;
            exp_y  = q[0].y;
            last_y = q[0].y;
            void'(q.pop_front());
        end
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("rsp_y", rsp_y, exp_y);
        check("halted", 32'(halted), 32'(mode == M_HALT));
        check("busy", 32'(busy), 32'(q.size() > 0));
        for (int i = 0; i < NREQ; i++) begin
            if (rsp_valid[i]) begin
                dut_rsps.push_back(i);
                seen_y[i]   = rsp_y;
                seen_lat[i] = n - gedge[i];
            end
        end
    endtask

    initial begin
        int ng, nr, got, last_g;
        int  rsp2;
        logic d;
        logic [31:0] exp_ovf;

        reset = 1'b0; drain = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; op_a[i] = '0; op_b[i] = '0;
            seen_y[i] = '0; gedge[i] = 0; seen_lat[i] = -1;
        end
        gen_mask = '0; gen_pct = 0;
        n = 0; mode = M_RUN; ptr = 0; last_y = '0;
        @(negedge clock);

        // Reset state
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);

        // Single requester, directed operands
        op_a[0] = 32'h0003_0201;
        op_b[0] = 32'hFE02_0408;
        pend[0] = 1'b1;
        repeat (LAT + 3) cycle(1'b1, 1'b0);
        check("single_y", seen_y[0], 32'hFE05_0609);
        check("single_lat", 32'(seen_lat[0]), 32'(LAT));

        // All requesters continuously valid from reset
        cycle(1'b0, 1'b0);
        dut_grants.delete(); dut_rsps.delete();
        gen_mask = 4'hF; gen_pct = 100;
        repeat (12) cycle(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            got = (dut_grants.size() > i) ? dut_grants[i] : -1;
            check("rr_grant_order", 32'(got), 32'(i % NREQ));
            got = (dut_rsps.size() > i) ? dut_rsps[i] : -1;
            check("rr_rsp_order", 32'(got), 32'(i % NREQ));
        end

        // Lane overflow
        gen_mask = '0;
        repeat (8) cycle(1'b1, 1'b0);
        op_a[1] = 32'h649C_649C;
        op_b[1] = 32'h649C_649C;
        pend[1] = 1'b1;
        repeat (LAT + 3) cycle(1'b1, 1'b0);
`ifdef DSP_ADD_ARB_SAT_EN
        exp_ovf = 32'h7F80_7F80;
`else
        exp_ovf = 32'hC838_C838;
`endif
        check("overflow_y", seen_y[1], exp_ovf);

        // Drain with two operations in flight
        gen_mask = 4'hF; gen_pct = 100;
        repeat (3) cycle(1'b1, 1'b0);
        last_g = (dut_grants.size() > 0) ? dut_grants[dut_grants.size()-1] : 0;
        ng = dut_grants.size();
        nr = dut_rsps.size();
        repeat (6) cycle(1'b1, 1'b1);
        check("drain_no_grant", 32'(dut_grants.size()), 32'(ng));
        check("drain_rsp_count", 32'(dut_rsps.size() - nr), 32'd2);
        check("drain_halted", 32'(halted), 32'd1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        got = (dut_grants.size() > ng) ? dut_grants[ng] : -1;
        check("resume_ptr", 32'(got), 32'((last_g + 1) % NREQ));

        // Reset one cycle after a grant
        gen_mask = '0;
        repeat (8) cycle(1'b1, 1'b0);
        gen_mask = 4'b0100;
        ng = dut_grants.size();
        for (int t = 0; t < 10 && dut_grants.size() == ng; t++) cycle(1'b1, 1'b0);
        check("rst_grant_seen", 32'(dut_grants.size() > ng), 32'd1);
        gen_mask = '0;
        pend[0] = 1'b1;
        op_a[0] = $urandom;
        op_b[0] = $urandom;
        nr = dut_rsps.size();
        ng = dut_grants.size();
        cycle(1'b0, 1'b0);
        repeat (LAT + 4) cycle(1'b1, 1'b0);
        rsp2 = 0;
        for (int i = nr; i < dut_rsps.size(); i++) if (dut_rsps[i] == 2) rsp2++;
        check("rst_discard", 32'(rsp2), 32'd0);
        got = (dut_grants.size() > ng) ? dut_grants[ng] : -1;
        check("rst_first_grant", 32'(got), 32'd0);

        // Randomized traffic with sporadic drain
        gen_mask = 4'hF; gen_pct = 50;
        d = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(9) == 0) d = ~d;
            cycle(1'b1, d);
        end
        repeat (LAT + 4) cycle(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_add_arbiter.md
# dsp_add_arbiter

Round-robin scheduler that shares one pipelined 4-lane signed 8-bit SIMD adder (the DSP add datapath) among NREQ requesters. Each requester issues operand pairs over a valid/ready handshake. The block returns each result, tagged by a one-hot response valid, a fixed LAT cycles later. A drain control lets the system quiesce the adder before reconfiguration, e.g. around the 5000-cycle GSR window.

## Interface
- NREQ, 4: number of requesters; 2..8.
- LAT, 2: adder pipeline depth in cycles; ≥1.
- clock  in  1  clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  requester i has an operand pair.
- req_ready  out  NREQ  requester i granted this cycle.
- req_a  in  NREQ*32  operand A of requester i at bits [32i+31:32i]; lane k at [8k+7:8k] within that word.
- req_b  in  NREQ*32  operand B, same layout.
- rsp_valid  out  NREQ  one-hot; result for requester i present on rsp_y.
- rsp_y  out  32  4 result lanes, shared by all requesters.
- drain  in  1  stop granting new requests.
- halted  out  1  drain is held and the pipeline is empty.
- busy  out  1  at least one operation is in flight.

## Operation
- FSM states:
  - RUN: grants allowed. Goes to DRAIN when drain=1.
  - DRAIN: no grants. Goes to HALT when the pipeline is empty, or to RUN if drain drops first.
  - HALT: halted=1. Goes to RUN when drain=0.
- If drain=1 and the pipeline is already empty in RUN, the FSM goes directly to HALT.
- Arbitration:
  - req_ready is combinational. At most one bit is set, and only in RUN.
  - The grant goes to the first valid requester searching from ptr upward, wrapping at NREQ.
- Pointer: on each accepted transfer (valid&ready) to requester g, ptr becomes (g+1) mod NREQ. With no transfer, ptr holds.
- Requester protocol: a requester must hold req_valid, req_a and req_b stable until the transfer completes. The arbiter never withdraws a grant while req_valid is still asserted within the same cycle.
- Pipeline:
  - On transfer, the operands and a one-hot tag of the granted requester enter the stage-1 registers.
  - Each stage carries a valid bit, and the operation advances one stage per cycle with no stall.
  - The final stage drives rsp_y and rsp_valid (tag AND valid).
  - rsp_valid has no backpressure; requesters must sink the result in that cycle.
- Arithmetic:
  - Each lane is an independent 8-bit add; there is no carry between lanes.
  - Default: two's-complement wrap modulo 256.
- busy: OR of all stage valid bits.
- rsp_y holds its last value when rsp_valid=0.

## Timing
- Reset (reset=0 at an edge) produces:
  - ptr=0, state=RUN;
  - all stage valids=0;
  - rsp_valid=0, rsp_y=0, halted=0, busy=0;
  - req_ready=0 while reset is low.
- Reset mid-operation discards in-flight operations silently; no rsp_valid follows.
- Latency: a transfer at edge k gives rsp_valid high for exactly one cycle, following edge k+LAT.
- Throughput: one transfer per cycle.
- Simultaneous drain=1 and a pending request: no grant that cycle.
- Simultaneous drain rise and an operation in flight: the operation completes normally.
- In HALT, halted rises on the edge after the last stage empties. It falls on the edge after drain drops.

## Configuration
- DSP_ADD_ARB_SAT_EN:
  - Defined: each lane saturates to the signed range [-128, 127].
  - Undefined: each lane wraps modulo 256.
- The macro affects only the final-stage lane arithmetic. Latency and handshake are identical either way.

## Structure
- Package dsp_add_arb_pkg holds:
  - WIDTH=8, LANES=4;
  - the state enum {RUN, DRAIN, HALT};
  - the lane-add function, with the saturating variant under the macro.
- Sub-module dsp_add_pipe(LAT) holds the LAT-stage operand/tag/valid shift pipeline and the lane adders.
- The arbiter top holds the FSM, the pointer and the grant logic.

## Test plan
- Single requester: a={0,3,2,1}, b={-2,2,4,8} on requester 0 → rsp_valid[0] exactly LAT cycles later with rsp_y lanes {-2,5,6,9}.
- All 4 requesters valid continuously from reset → grants in order 0,1,2,3,0… one per cycle, and rsp_valid follows the same order delayed by LAT.
- Lane overflow: 100+100 and -100+-100 → 127 and -128 with DSP_ADD_ARB_SAT_EN; -56 and 56 without.
- Drain with 2 operations in flight → no grants; both results return; halted rises after the second result; after drain=0, RUN resumes with ptr preserved.
- Reset asserted 1 cycle after a grant → no rsp_valid ever appears for that operation; all outputs are 0; the first grant after reset goes to requester 0.
